// File: rtl/hb_decim_fsm.sv
// rtl/hb_decim_fsm.sv - 11-tap halfband decimate-by-2 FIR sharing one multiplier under FSM control
module hb_decim_fsm #(
    parameter int DW = 16,
    parameter int H0 = 331,
    parameter int H2 = -1904,
    parameter int H4 = 9765,
    parameter int HC = 16384
) (
    input  logic                 CLKDIVC1,
    input  logic                 RST,
    input  logic signed [DW-1:0] x_in,
    input  logic                 x_valid,
    output logic signed [DW-1:0] y_out,
    output logic                 y_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic                 sat
);

    localparam int CW = 16;
    localparam int PW = DW + 1;
    localparam int MW = PW + CW;
    // Four products of MW bits need two guard bits on top.
    localparam int AW = (2*DW+3 > MW+2) ? 2*DW+3 : MW+2;

    localparam logic signed [AW-1:0] RND  = AW'(16384);
    localparam logic signed [AW-1:0] YMAX = (AW'(1) <<< (DW-1)) - AW'(1);
    localparam logic signed [AW-1:0] YMIN = -(AW'(1) <<< (DW-1));

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [1:0]             k;
    logic                   phase;
    logic signed [DW-1:0]   dl [0:10];
    logic signed [AW-1:0]   acc;

    logic                   accept;
    logic                   trigger;
    logic signed [DW-1:0]   op_a;
    logic signed [DW-1:0]   op_b;
    logic signed [CW-1:0]   coef;
    logic signed [PW-1:0]   pre;
    logic signed [MW-1:0]   prod;
    logic signed [AW-1:0]   prod_ext;
    logic signed [AW-1:0]   rsum;
    logic signed [AW-1:0]   rnd;
    logic signed [DW-1:0]   y_sat;
    logic                   clip;

    assign accept  = x_valid && (state == IDLE);
    assign trigger = accept && phase;
    assign busy    = (state != IDLE);

    always_ff @(posedge CLKDIVC1 or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = MAC;
            MAC:     if (k == 2'd3) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Symmetric tap pairs are pre-added so each step needs a single multiply.
    always_comb begin
        op_a = dl[5];
        op_b = '0;
        coef = CW'(HC);
        case (k)
            2'd0: begin op_a = dl[0]; op_b = dl[10]; coef = CW'(H0); end
            2'd1: begin op_a = dl[2]; op_b = dl[8];  coef = CW'(H2); end
            2'd2: begin op_a = dl[4]; op_b = dl[6];  coef = CW'(H4); end
            default: begin op_a = dl[5]; op_b = '0;  coef = CW'(HC); end
        endcase
    end

    assign pre      = {op_a[DW-1], op_a} + {op_b[DW-1], op_b};
    assign prod     = pre * coef;
    assign prod_ext = AW'(prod);
    assign rsum     = acc + RND;
    assign rnd      = rsum >>> 15;

    always_comb begin
        y_sat = rnd[DW-1:0];
        clip  = 1'b0;
        if (rnd > YMAX) begin
            y_sat = YMAX[DW-1:0];
            clip  = 1'b1;
        end else if (rnd < YMIN) begin
            y_sat = YMIN[DW-1:0];
            clip  = 1'b1;
        end
    end

    always_ff @(posedge CLKDIVC1 or posedge RST) begin
        if (RST) begin
            phase   <= 1'b0;
            k       <= 2'd0;
            acc     <= '0;
            y_out   <= '0;
            y_valid <= 1'b0;
            sat     <= 1'b0;
            overrun <= 1'b0;
            for (int i = 0; i <= 10; i++) begin
                dl[i] <= '0;
            end
        end else begin
            y_valid <= 1'b0;
            sat     <= 1'b0;
            if (x_valid && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            if (accept) begin
                for (int i = 10; i > 0; i--) begin
                    dl[i] <= dl[i-1];
                end
                dl[0] <= x_in;
                phase <= ~phase;
            end
            case (state)
                IDLE: begin
                    if (trigger) begin
                        acc <= '0;
                        k   <= 2'd0;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    k   <= k + 2'd1;
                end
                OUT: begin
                    y_out   <= y_sat;
                    y_valid <= 1'b1;
                    sat     <= clip;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hb_decim_fsm.sv
// tb/tb_hb_decim_fsm.sv - directed table-driven bench for hb_decim_fsm
module tb_hb_decim_fsm;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] x_in;
    logic               x_valid;
    logic signed [15:0] y_out;
    logic               y_valid;
    logic               busy;
    logic               overrun;
    logic               sat;

    int tests  = 0;
    int failed = 0;

    hb_decim_fsm dut (
        .CLKDIVC1 (clk),
        .RST      (rst),
        .x_in     (x_in),
        .x_valid  (x_valid),
        .y_out    (y_out),
        .y_valid  (y_valid),
        .busy     (busy),
        .overrun  (overrun),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                 rst_before;
        logic signed [15:0] x;
        bit                 exp_valid;
        bit                 chk;
        int                 exp_y;
        int                 exp_sat;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic send(input logic signed [15:0] s);
        @(negedge clk);
        x_in    = s;
        x_valid = 1'b1;
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    task automatic wait_valid(input int maxc, output bit seen, output int lat,
                              output int y, output int s);
        seen = 1'b0; lat = 0; y = 0; s = 0;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (y_valid && !seen) begin
                seen = 1'b1;
                lat  = i;
                y    = y_out;
                s    = sat;
            end
        end
    endtask

    task automatic push(input logic signed [15:0] s, output bit seen, output int lat,
                        output int y, output int st, output int b);
        send(s);
        b = busy;
        wait_valid(7, seen, lat, y, st);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   imp [7] = '{10, -58, 298, 298, -58, 10, 0};
        bit   seen;
        int   lat, y, s, b;

        rst = 1'b1; x_valid = 1'b0; x_in = '0;

        // Impulse: 0,1000,0,0,...
        for (int i = 1; i <= 14; i++) begin
            v.rst_before = (i == 1);
            v.x          = (i == 2) ? 16'sd1000 : 16'sd0;
            v.exp_valid  = (i % 2 == 0);
            v.chk        = 1'b1;
            v.exp_y      = (i % 2 == 0) ? imp[i/2-1] : 0;
            v.exp_sat    = 0;
            vt.push_back(v);
        end
        // DC 10000: settled from the 6th output
        for (int i = 1; i <= 14; i++) begin
            v.rst_before = (i == 1);
            v.x          = 16'sd10000;
            v.exp_valid  = (i % 2 == 0);
            v.chk        = (i >= 12);
            v.exp_y      = 10000;
            v.exp_sat    = 0;
            vt.push_back(v);
        end
        // Positive saturation on the 6th output
        for (int i = 1; i <= 12; i++) begin
            v.rst_before = (i == 1);
            if (i == 2 || i == 6 || i == 7 || i == 8 || i == 12) v.x = 16'sd32767;
            else if (i == 4 || i == 10)                          v.x = -16'sd32768;
            else                                                 v.x = 16'sd0;
            v.exp_valid  = (i % 2 == 0);
            v.chk        = (i == 12);
            v.exp_y      = 32767;
            v.exp_sat    = 1;
            vt.push_back(v);
        end

        repeat (2) @(negedge clk);
        chk("rst_y_out",   y_out,   0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_busy",    busy,    0);
        chk("rst_overrun", overrun, 0);
        chk("rst_sat",     sat,     0);
        rst = 1'b0;

        foreach (vt[n]) begin
            if (vt[n].rst_before) do_reset();
            push(vt[n].x, seen, lat, y, s, b);
            chk($sformatf("vec%0d_valid", n), seen, vt[n].exp_valid);
            chk($sformatf("vec%0d_busy", n), b, vt[n].exp_valid);
            if (vt[n].exp_valid && vt[n].chk) begin
                chk($sformatf("vec%0d_y", n), y, vt[n].exp_y);
                chk($sformatf("vec%0d_sat", n), s, vt[n].exp_sat);
                chk($sformatf("vec%0d_lat", n), lat, 5);
            end
        end

        // Overrun: input two cycles after a triggering accept is dropped
        do_reset();
        push(16'sd0, seen, lat, y, s, b);
        chk("ovr_pre_valid", seen, 0);
        send(16'sd1000);
        @(negedge clk);
        x_in = 16'sd12345; x_valid = 1'b1;
        @(negedge clk);
        x_valid = 1'b0;
        chk("ovr_flag", overrun, 1);
        chk("ovr_busy", busy, 1);
        wait_valid(6, seen, lat, y, s);
        chk("ovr_valid", seen, 1);
        chk("ovr_lat", lat, 3);
        chk("ovr_y", y, 10);
        push(16'sd0, seen, lat, y, s, b);
        chk("ovr_phase_valid", seen, 0);
        chk("ovr_sticky", overrun, 1);
        push(16'sd0, seen, lat, y, s, b);
        chk("ovr_next_valid", seen, 1);
        chk("ovr_next_y", y, -58);

        // Reset mid-MAC aborts the computation
        send(16'sd0);
        send(16'sd1000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_y_out",   y_out,   0);
        chk("abort_y_valid", y_valid, 0);
        chk("abort_busy",    busy,    0);
        chk("abort_overrun", overrun, 0);
        chk("abort_sat",     sat,     0);
        @(negedge clk);
        rst = 1'b0;
        wait_valid(8, seen, lat, y, s);
        chk("abort_no_valid", seen, 0);

        // Back-to-back accepts after a non-triggering sample
        @(negedge clk);
        x_in = 16'sd0; x_valid = 1'b1;
        @(negedge clk);
        x_in = 16'sd1000;
        @(negedge clk);
        x_valid = 1'b0;
        wait_valid(7, seen, lat, y, s);
        chk("b2b_valid", seen, 1);
        chk("b2b_lat", lat, 5);
        chk("b2b_y", y, 10);
        chk("b2b_sat", s, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
